// File: rtl/carloni_pkg.sv
// Shared types and constants for the Carloni latency-insensitive channel.
package carloni_pkg;

   typedef enum logic [1:0] {
      TX_EMPTY = 2'd0,
      TX_HALF  = 2'd1,
      TX_FULL  = 2'd2
   } tx_state_t;

   // Receiver stop is registered once, so one extra token can be launched after it: two slots suffice.
   localparam int unsigned CARLONI_STOP_LATENCY = 1;

endpackage

// File: rtl/carloni_tx_port.sv
// Transmitter end of a Carloni channel: two-slot (main + aux) buffer between the
// producing pearl and the channel, honouring the receiver's registered stop.
module carloni_tx_port
   import carloni_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_valid,
   output logic             o_stall,
   output logic [WIDTH-1:0] o_data,
   output logic             o_void,
   input  logic             i_stop,
   output logic [CNT_W-1:0] o_tokens
);

   tx_state_t        state, state_nxt;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] aux_q, aux_d;
   logic             accept;
   logic             transfer;

   assign accept   = i_valid & ~o_stall;
   assign transfer = ~o_void & ~i_stop;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= TX_EMPTY;
         main_q   <= '0;
         aux_q    <= '0;
         o_tokens <= '0;
      end else begin
         state  <= state_nxt;
         main_q <= main_d;
         aux_q  <= aux_d;
         if (transfer)
            o_tokens <= o_tokens + CNT_W'(1);
      end
   end

   always_comb begin
      state_nxt = TX_EMPTY;
      main_d    = main_q;
      aux_d     = aux_q;
      case (state)
         TX_EMPTY: begin
            if (accept) begin
               main_d    = i_data;
               state_nxt = TX_HALF;
            end
         end
         TX_HALF: begin
            if (!i_stop) begin
               // Main is drained this cycle, so a new token can replace it directly.
               if (accept) begin
                  main_d    = i_data;
                  state_nxt = TX_HALF;
               end
            end else if (accept) begin
               aux_d     = i_data;
               state_nxt = TX_FULL;
            end else begin
               state_nxt = TX_HALF;
            end
         end
         TX_FULL: begin
            if (!i_stop) begin
               main_d    = aux_q;
               state_nxt = TX_HALF;
            end else begin
               state_nxt = TX_FULL;
            end
         end
         default: state_nxt = TX_EMPTY;
      endcase
   end

   always_comb begin
      o_void  = !(state == TX_HALF || state == TX_FULL);
      o_stall = (state == TX_FULL);
      o_data  = main_q;
   end

endmodule
